// File: rtl/platform_pkg.sv
// Shared platform types: reset cause encoding, sequencer states and count helpers.
package platform_pkg;

   localparam int unsigned RESET_COUNT_W = 8;

   typedef enum logic [1:0] {
      CAUSE_POR       = 2'd0,
      CAUSE_LOCK_LOSS = 2'd1,
      CAUSE_BUTTON    = 2'd2,
      CAUSE_SOFTWARE  = 2'd3
   } reset_cause_e;

   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2
   } seq_state_e;

   // Saturating increment for the reset counter
   function automatic logic [RESET_COUNT_W-1:0] sat_inc(input logic [RESET_COUNT_W-1:0] v);
      return (&v) ? v : v + RESET_COUNT_W'(1);
   endfunction

endpackage

// File: rtl/sync_debounce.sv
// Multi-flop synchroniser followed by a consecutive-sample debouncer.
module sync_debounce #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter logic        RESET_LEVEL     = 1'b1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic async_i,
   output logic level_o
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   synced;
   logic [CNT_W-1:0]       cnt_q;
   logic                   level_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) sync_q <= {SYNC_STAGES{RESET_LEVEL}};
      else       sync_q <= SYNC_STAGES'({sync_q, async_i});
   end

   assign synced = sync_q[SYNC_STAGES-1];

   // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q   <= '0;
         level_q <= RESET_LEVEL;
      end else if (synced == level_q) begin
         cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
         cnt_q   <= '0;
         level_q <= synced;
      end else begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign level_o = level_q;

endmodule

// File: rtl/platform_reset_seq.sv
// Platform reset sequencer: gathers lock/button/software causes and releases
// reset domains in order with a fixed gap, recording cause and reset count.
module platform_reset_seq
   import platform_pkg::*;
#(
   parameter int unsigned NUM_LOCKS       = 3,
   parameter int unsigned NUM_DOMAINS     = 4,
   parameter int unsigned STAGE_DELAY     = 8,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [NUM_LOCKS-1:0]     locked_i,
   input  logic                     btn_rstn_i,
   input  logic                     sw_rst_req_i,
   output logic [NUM_DOMAINS-1:0]   rst_o,
   output logic                     all_released_o,
   output logic [1:0]               cause_o,
   output logic [RESET_COUNT_W-1:0] reset_count_o
);

   localparam int unsigned CNT_W = $clog2(STAGE_DELAY + 1);
   localparam int unsigned IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

   if (STAGE_DELAY < SYNC_STAGES) begin : g_param_check
      $error("platform_reset_seq: STAGE_DELAY must be >= SYNC_STAGES");
   end

   logic [NUM_LOCKS-1:0] lock_synced;
   logic                 all_locked;
   logic                 btn_level;
   logic                 btn_pressed;
   logic                 trigger;

   for (genvar g = 0; g < NUM_LOCKS; g++) begin : g_lock_sync
      logic [SYNC_STAGES-1:0] sh_q;
      always_ff @(posedge clk_i) begin
         if (rst_i) sh_q <= '0;
         else       sh_q <= SYNC_STAGES'({sh_q, locked_i[g]});
      end
      assign lock_synced[g] = sh_q[SYNC_STAGES-1];
   end

   sync_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_LEVEL     (1'b1)
   ) u_btn_db (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .async_i (btn_rstn_i),
      .level_o (btn_level)
   );

   assign all_locked  = &lock_synced;
   assign btn_pressed = ~btn_level;
   assign trigger     = ~all_locked | btn_pressed | sw_rst_req_i;

   seq_state_e               state_q, state_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic [NUM_DOMAINS-1:0]   rst_q, rst_d;
   logic                     released_q, released_d;
   reset_cause_e             cause_q, cause_d;
   logic [RESET_COUNT_W-1:0] count_q, count_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_HOLD;
         cnt_q      <= CNT_W'(STAGE_DELAY);
         idx_q      <= '0;
         rst_q      <= '1;
         released_q <= 1'b0;
         cause_q    <= CAUSE_POR;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         rst_q      <= rst_d;
         released_q <= released_d;
         cause_q    <= cause_d;
         count_q    <= count_d;
      end
   end

   // A trigger outranks any release scheduled for the same edge
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      rst_d      = rst_q;
      released_d = 1'b0;
      cause_d    = cause_q;
      count_d    = count_q;
      unique case (state_q)
         ST_HOLD: begin
            rst_d = '1;
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (all_locked && !btn_pressed) begin
               state_d = ST_RELEASE;
               cnt_d   = CNT_W'(STAGE_DELAY);
               idx_d   = '0;
            end
         end
         ST_RELEASE, ST_RUN: begin
            if (trigger) begin
               state_d = ST_HOLD;
               cnt_d   = CNT_W'(STAGE_DELAY);
               idx_d   = '0;
               rst_d   = '1;
               count_d = sat_inc(count_q);
               if (!all_locked)     cause_d = CAUSE_LOCK_LOSS;
               else if (btn_pressed) cause_d = CAUSE_BUTTON;
               else                  cause_d = CAUSE_SOFTWARE;
            end else if (state_q == ST_RUN) begin
               rst_d      = '0;
               released_d = 1'b1;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               rst_d[idx_q] = 1'b0;
               if (idx_q == IDX_W'(NUM_DOMAINS - 1)) begin
                  state_d    = ST_RUN;
                  released_d = 1'b1;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
                  cnt_d = CNT_W'(STAGE_DELAY);
               end
            end
         end
         default: state_d = ST_HOLD;
      endcase
   end

   assign rst_o          = rst_q;
   assign all_released_o = released_q;
   assign cause_o        = cause_q;
   assign reset_count_o  = count_q;

endmodule

// File: doc/platform_reset_seq.md
# platform_reset_seq

Parametrised reset sequencer for the FPGA top level. It replaces the ad-hoc lock synchronisers with one block: it synchronises N clock-wizard lock inputs and debounces the board reset button. It also accepts a software reset request and releases M reset domains in a fixed order, with a programmable gap between each. It records the cause of the last reset and counts resets so the platform can report them.

## Interface
Parameters:
- NUM_LOCKS, 3, number of asynchronous lock inputs; all must be high to leave reset
- NUM_DOMAINS, 4, number of reset outputs; released bit 0 first, bit NUM_DOMAINS-1 last
- STAGE_DELAY, 8, cycles counted per hold/release stage; must satisfy STAGE_DELAY >= SYNC_STAGES (elaboration error otherwise)
- SYNC_STAGES, 2, synchroniser depth for `locked_i` and `btn_rstn_i`
- DEBOUNCE_CYCLES, 16, consecutive stable synced samples needed to change the debounced button level

Ports:
- clk_i  in  1  single clock
- rst_i  in  1  reset, synchronous and active-high
- locked_i  in  NUM_LOCKS  asynchronous clock-wizard lock flags
- btn_rstn_i  in  1  asynchronous board button, active low
- sw_rst_req_i  in  1  single-cycle software reset request from platform CSR
- rst_o  out  NUM_DOMAINS  per-domain reset, active high
- all_released_o  out  1  high only in RUN
- cause_o  out  2  last reset cause: 0 POR, 1 LOCK_LOSS, 2 BUTTON, 3 SOFTWARE
- reset_count_o  out  8  resets since `rst_i`; saturates at 255

## Operation
- Synchronisers: `locked_i` bits and `btn_rstn_i` pass through SYNC_STAGES flops. Flops reset to 0 (locks) and 1 (button released). `all_locked` is the AND of the synced lock bits.
- Debounce: `btn_db` toggles only after the synced button level has differed from `btn_db` for DEBOUNCE_CYCLES consecutive cycles. Any matching sample clears the counter. Reset value is "not pressed".
- FSM states are HOLD, RELEASE and RUN. Stage counter `cnt` and domain index `idx` are kept alongside.
- On `rst_i`:
  - state HOLD, `cnt` = STAGE_DELAY, `idx` = 0
  - `rst_o` all ones, `all_released_o` 0
  - `cause_o` POR, `reset_count_o` 0
- HOLD:
  - `rst_o` all ones.
  - If `cnt` > 0, decrement it.
  - If `cnt` == 0 and `all_locked` and the button is not pressed, go to RELEASE, reload `cnt` = STAGE_DELAY, `idx` = 0.
  - `sw_rst_req_i` is ignored in HOLD.
- RELEASE:
  - If `cnt` > 0, decrement it.
  - If `cnt` == 0, clear `rst_o[idx]` (registered, on the same edge as the transition).
  - Then, if `idx` == NUM_DOMAINS-1, go to RUN. Otherwise increment `idx` and reload `cnt`.
- RUN: `all_released_o` = 1 and `rst_o` all zero.
- Trigger in RELEASE or RUN (`all_locked` low, `btn_db` pressed, or `sw_rst_req_i`). On the next edge:
  - `rst_o` all ones
  - state HOLD, `cnt` = STAGE_DELAY
  - `cause_o` updated, priority LOCK_LOSS > BUTTON > SOFTWARE
  - `reset_count_o` incremented (saturating)
- A button still held or a lock still low keeps the block in HOLD indefinitely. `cause_o` is not updated again while in HOLD.

## Timing
- Lock and button latency from pin to FSM: SYNC_STAGES cycles, plus DEBOUNCE_CYCLES for the button.
- Reference schedule, counting edges with `rst_i` low from the first one (locks stable high, button released):
  - HOLD exits at edge STAGE_DELAY+1.
  - `rst_o[i]` falls at edge (i+2)·(STAGE_DELAY+1).
  - `all_released_o` rises on the same edge as `rst_o[NUM_DOMAINS-1]` falls.
- Trigger to full reassertion: 1 cycle after the trigger reaches the FSM.
- A trigger on the same edge as a scheduled release: the trigger wins and the domain stays in reset.
- `rst_o` bits are direct flop outputs with no combinational path from inputs.

## Structure
- Add `reset_cause_e` (POR, LOCK_LOSS, BUTTON, SOFTWARE) to `platform_pkg`. `cause_o` is driven from it.
- Sub-module `sync_debounce`, parameters SYNC_STAGES and DEBOUNCE_CYCLES: synchroniser plus debouncer, used for the button.
- Lock bits use the synchroniser only, via a generate loop.

## Test plan
- Defaults, locks high, `rst_i` pulse → `rst_o` = 4'hF. Bits 0..3 fall at edges 18/27/36/45. `all_released_o` rises at 45. `cause_o` = 0, `reset_count_o` = 0.
- In RUN, drop `locked_i[1]` for 3 cycles → `rst_o` = 4'hF 3 cycles after the drop. `cause_o` = 1, count = 1. After lock returns, the full release sequence replays.
- `btn_rstn_i` low for 10 cycles → no reset. Low for 30 cycles → reset with `cause_o` = 2. Domains stay in reset until the debounced release plus 9 cycles.
- `sw_rst_req_i` pulse in RUN → `cause_o` = 3 and all domains reset. A second pulse during HOLD is ignored and count increments only once.
- Lock loss and software request on the same cycle during RELEASE (`idx` = 2) → `cause_o` = 1 and `rst_o` = 4'hF.
- Apply 300 software resets → `reset_count_o` saturates at 255. `rst_i` mid-RELEASE → all outputs return to reset values on the next edge.
